// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types for the DMA priority arbiter: channel count, channel index and FSM states.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] ch_id_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_GRANT
  } arb_state_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_id_t id);
    ch_onehot     = '0;
    ch_onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge bundle between the DMA channels, the bus master and the arbiter.
interface dma_priority_arbiter_if;
  import dma_pkg::*;

  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] MASK;
  logic              ROTATE;
  logic              HLDA;
  logic              EOP_DONE;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  ch_id_t            CH_ID;
  logic              CH_VALID;

  // master: the surrounding system driving requests; slave: the arbiter itself
  modport master (
    output DREQ, MASK, ROTATE, HLDA, EOP_DONE,
    input  HRQ, DACK, CH_ID, CH_VALID
  );

  modport slave (
    input  DREQ, MASK, ROTATE, HLDA, EOP_DONE,
    output HRQ, DACK, CH_ID, CH_VALID
  );

endinterface

// File: rtl/dma_priority_arbiter_pick.sv
// Combinational priority picker: fixed (ch0 highest) or rotating from low_ptr+1.
module dma_prio_pick
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] pending,
  input  ch_id_t            low_ptr,
  input  logic              rotate,
  output ch_id_t            winner,
  output logic              found
);

  ch_id_t base;
  ch_id_t idx;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    base   = rotate ? ch_id_t'(low_ptr + 2'd1) : '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = base + ch_id_t'(NUM_CH - 1 - i);
      if (pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: requests the bus via HRQ/HLDA and grants one channel until EOP_DONE.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input logic                  CLK,
  input logic                  RESET_N,
  dma_priority_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic              hrq_q, hrq_d;
  logic [NUM_CH-1:0] dack_q, dack_d;
  ch_id_t            ch_id_q, ch_id_d;
  logic              valid_q, valid_d;
  ch_id_t            low_ptr, low_ptr_d;

  logic [NUM_CH-1:0] pending;
  ch_id_t            winner;
  logic              found;

  assign pending = bus.DREQ & ~bus.MASK;

  dma_prio_pick u_pick (
    .pending (pending),
    .low_ptr (low_ptr),
    .rotate  (bus.ROTATE),
    .winner  (winner),
    .found   (found)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ARB_IDLE;
      hrq_q   <= 1'b0;
      dack_q  <= '0;
      ch_id_q <= '0;
      valid_q <= 1'b0;
      low_ptr <= 2'd3;
    end else begin
      state_q <= state_d;
      hrq_q   <= hrq_d;
      dack_q  <= dack_d;
      ch_id_q <= ch_id_d;
      valid_q <= valid_d;
      low_ptr <= low_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hrq_d     = hrq_q;
    dack_d    = dack_q;
    ch_id_d   = ch_id_q;
    valid_d   = valid_q;
    low_ptr_d = low_ptr;
    unique case (state_q)
      ARB_IDLE: begin
        hrq_d   = |pending;
        dack_d  = '0;
        ch_id_d = '0;
        valid_d = 1'b0;
        if (|pending) state_d = ARB_REQ;
      end
      ARB_REQ: begin
        if (bus.HLDA && found) begin
          state_d = ARB_GRANT;
          hrq_d   = 1'b1;
          dack_d  = ch_onehot(winner);
          ch_id_d = winner;
          valid_d = 1'b1;
        end else if (bus.HLDA || !(|pending)) begin
          state_d = ARB_IDLE;
          hrq_d   = 1'b0;
        end else begin
          hrq_d = 1'b1;
        end
      end
      ARB_GRANT: begin
        // EOP_DONE wins over a simultaneous HLDA drop so rotation still advances.
        if (bus.EOP_DONE || !bus.HLDA) begin
          state_d = ARB_IDLE;
          hrq_d   = 1'b0;
          dack_d  = '0;
          ch_id_d = '0;
          valid_d = 1'b0;
          if (bus.EOP_DONE && bus.ROTATE) low_ptr_d = ch_id_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        hrq_d   = 1'b0;
        dack_d  = '0;
        ch_id_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.HRQ      = hrq_q;
  assign bus.DACK     = dack_q;
  assign bus.CH_ID    = ch_id_q;
  assign bus.CH_VALID = valid_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed and randomized checks of dma_priority_arbiter against a transaction-level model.
module tb_dma_priority_arbiter;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  dma_priority_arbiter_if bus ();

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who holds the bus, whether HRQ is up, and the last serviced channel.
  int m_gnt;
  bit m_hrq;
  int m_ptr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_ref(input logic [3:0] p, input bit rot, input int ptr);
    int first;
    first = rot ? (ptr + 1) % 4 : 0;
    for (int k = 0; k < 4; k++)
      if (p[(first + k) % 4]) return (first + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_gnt = -1;
    m_hrq = 1'b0;
    m_ptr = 3;
  endtask

  task automatic model_step();
    logic [3:0] p;
    p = bus.DREQ & ~bus.MASK;
    if (m_gnt >= 0) begin
      if (bus.EOP_DONE) begin
        if (bus.ROTATE) m_ptr = m_gnt;
        m_gnt = -1;
        m_hrq = 1'b0;
      end else if (!bus.HLDA) begin
        m_gnt = -1;
        m_hrq = 1'b0;
      end
    end else if (m_hrq && bus.HLDA) begin
      m_gnt = pick_ref(p, bus.ROTATE, m_ptr);
      m_hrq = (m_gnt >= 0);
    end else begin
      m_hrq = (p != 4'b0);
    end
  endtask

  task automatic compare_outputs();
    check_val("hrq", 32'(bus.HRQ), 32'(m_hrq));
    check_val("dack", 32'(bus.DACK), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
    check_val("ch_valid", 32'(bus.CH_VALID), (m_gnt >= 0) ? 32'd1 : 32'd0);
    if (m_gnt >= 0) check_val("ch_id", 32'(bus.CH_ID), 32'(m_gnt));
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    compare_outputs();
  endtask

  task automatic set_in(input logic [3:0] dreq, input logic [3:0] mask, input logic rot,
                        input logic hlda, input logic eop);
    bus.DREQ     = dreq;
    bus.MASK     = mask;
    bus.ROTATE   = rot;
    bus.HLDA     = hlda;
    bus.EOP_DONE = eop;
  endtask

  initial begin
    model_reset();
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_hrq", 32'(bus.HRQ), 32'd0);
    check_val("rst_dack", 32'(bus.DACK), 32'd0);
    check_val("rst_ch_id", 32'(bus.CH_ID), 32'd0);
    check_val("rst_valid", 32'(bus.CH_VALID), 32'd0);
    check_val("rst_low_ptr", 32'(dut.low_ptr), 32'd3);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Single channel: HRQ one edge after DREQ, grant one edge after HLDA, clear after EOP.
    set_in(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("s1_hrq_latency", 32'(bus.HRQ), 32'd1);
    tick();
    tick();
    bus.HLDA = 1'b1;
    tick();
    check_val("s1_dack", 32'(bus.DACK), 32'b0001);
    check_val("s1_ch_id", 32'(bus.CH_ID), 32'd0);
    bus.EOP_DONE = 1'b1;
    tick();
    check_val("s1_eop_clear", {29'd0, bus.HRQ, bus.CH_VALID, |bus.DACK}, 32'd0);
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();

    // Fixed priority: ch1 beats ch3 every time.
    set_in(4'b1010, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check_val("fix_first", 32'(bus.DACK), 32'b0010);
    bus.EOP_DONE = 1'b1;
    tick();
    bus.EOP_DONE = 1'b0;
    tick();
    tick();
    check_val("fix_again", 32'(bus.DACK), 32'b0010);
    bus.EOP_DONE = 1'b1;
    tick();

    // Rotating priority over four back-to-back services.
    set_in(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      check_val("rot_order", 32'(bus.CH_ID), 32'(i));
      bus.EOP_DONE = 1'b1;
      tick();
      bus.EOP_DONE = 1'b0;
    end
    check_val("rot_low_ptr", 32'(dut.low_ptr), 32'd3);

    // Masked request is invisible until the mask clears.
    set_in(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_val("mask_hrq_low", 32'(bus.HRQ), 32'd0);
    bus.MASK = 4'b0000;
    tick();
    check_val("unmask_hrq", 32'(bus.HRQ), 32'd1);

    // Request withdrawn before HLDA, then a late HLDA.
    bus.DREQ = 4'b0000;
    tick();
    check_val("withdraw_hrq", 32'(bus.HRQ), 32'd0);
    bus.HLDA = 1'b1;
    tick();
    check_val("late_hlda_dack", 32'(bus.DACK), 32'd0);
    set_in(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    check_val("hlda_no_pend", {30'd0, bus.HRQ, |bus.DACK}, 32'd0);

    // Bus revoked mid-grant on ch2; LOW_PTR must not move.
    set_in(4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check_val("abort_grant", 32'(bus.DACK), 32'b0100);
    bus.HLDA = 1'b0;
    tick();
    check_val("abort_dack", 32'(bus.DACK), 32'd0);
    check_val("abort_low_ptr", 32'(dut.low_ptr), 32'd3);
    bus.HLDA = 1'b1;
    tick();
    tick();
    bus.EOP_DONE = 1'b1;
    tick();
    check_val("eop_low_ptr", 32'(dut.low_ptr), 32'd2);
    bus.EOP_DONE = 1'b0;
    tick();
    tick();
    bus.DREQ = 4'b1111;
    tick();

    // Asynchronous reset in the middle of a grant.
    RESET_N = 1'b0;
    #1;
    check_val("arst_dack", 32'(bus.DACK), 32'd0);
    check_val("arst_hrq", 32'(bus.HRQ), 32'd0);
    check_val("arst_low_ptr", 32'(dut.low_ptr), 32'd3);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    tick();
    check_val("post_rst_pick", 32'(bus.DACK), 32'b0001);

    // EOP_DONE together with HLDA drop still rotates.
    set_in(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    check_val("eop_vs_hlda_ptr", 32'(dut.low_ptr), 32'd0);
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();

    for (int c = 0; c < 3000; c++) begin
      bus.DREQ     = 4'($urandom);
      bus.MASK     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 19) == 0) bus.ROTATE = ~bus.ROTATE;
      bus.HLDA     = ($urandom_range(0, 9) < 7);
      bus.EOP_DONE = ($urandom_range(0, 3) == 0);
      tick();
      if (c % 50 == 0) check_val("rand_low_ptr", 32'(dut.low_ptr), 32'(m_ptr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, meaning number of DMA channels; only 4 is supported.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low, with ports named CLK and RESET_N.
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 RESET_N  input  1  asynchronous active-low reset.
REQ-005 DREQ  input  4  channel requests, active high, already synchronous to CLK.
REQ-006 MASK  input  4  per-channel mask; 1 = channel ignored.
REQ-007 ROTATE  input  1  0 = fixed priority (ch0 highest), 1 = rotating priority.
REQ-008 HLDA  input  1  hold acknowledge from the bus master.
REQ-009 EOP_DONE  input  1  one-cycle pulse from timing/control: current service finished.
REQ-010 HRQ  output  1  hold request to the bus master.
REQ-011 DACK  output  4  one-hot, active-high channel acknowledge.
REQ-012 CH_ID  output  2  binary index of granted channel.
REQ-013 CH_VALID  output  1  grant active; qualifies CH_ID for timing/control.

Function
REQ-014 The arbiter SHALL implement states ARB_IDLE, ARB_REQ, ARB_GRANT; all outputs are registered.
REQ-015 "pending" SHALL mean DREQ & ~MASK, evaluated every cycle.
REQ-016 ARB_IDLE -> ARB_REQ when pending != 0; HRQ SHALL be 1 from the following edge (1-cycle latency).
REQ-017 In ARB_REQ, HRQ SHALL stay 1 while pending != 0 and HLDA = 0.
REQ-018 ARB_REQ with pending == 0 and HLDA = 0 -> ARB_IDLE; HRQ SHALL drop on that edge.
REQ-019 ARB_REQ with HLDA = 1 and pending != 0 -> ARB_GRANT; the winner is chosen from pending in that cycle.
REQ-020 On that edge, DACK SHALL be one-hot on the winner, CH_ID = winner, CH_VALID = 1, and HRQ stays 1.
REQ-021 ARB_REQ with HLDA = 1 and pending == 0 -> ARB_IDLE; HRQ drops and no DACK is issued.
REQ-022 Fixed mode SHALL order priority ch0 > ch1 > ch2 > ch3.
REQ-023 Rotating mode SHALL give highest priority to channel (LOW_PTR+1) mod 4, descending modulo 4.
REQ-024 LOW_PTR is a 2-bit register that wraps 3 -> 0.
REQ-025 In ARB_GRANT, grant outputs SHALL hold unchanged regardless of DREQ or MASK changes.
REQ-026 ARB_GRANT with EOP_DONE = 1 -> ARB_IDLE; DACK = 0, CH_VALID = 0, HRQ = 0 from the next edge.
REQ-027 If ROTATE = 1 at that EOP_DONE edge, LOW_PTR SHALL load the serviced CH_ID.
REQ-028 ARB_GRANT with HLDA = 0 (bus revoked) SHALL abort to ARB_IDLE with outputs cleared and LOW_PTR unchanged.
REQ-029 If EOP_DONE and HLDA = 0 occur together, EOP_DONE SHALL take precedence (rotation applies).
REQ-030 EOP_DONE outside ARB_GRANT SHALL be ignored.
REQ-031 At least one cycle in ARB_IDLE SHALL separate two grants: HRQ low for at least one cycle.
REQ-032 DACK SHALL never have more than one bit set; CH_VALID SHALL equal |DACK.

Reset
REQ-033 RESET_N low SHALL immediately force: state ARB_IDLE, HRQ = 0, DACK = 4'b0000, CH_ID = 0, CH_VALID = 0, LOW_PTR = 3.
REQ-034 Reset asserted mid-grant SHALL drop all outputs asynchronously; the first request after release arbitrates from the reset priority.

Structure
REQ-035 Package dma_pkg SHALL hold NUM_CH, typedef ch_id_t (2-bit), and enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_GRANT}.
REQ-036 A combinational sub-module dma_prio_pick SHALL map (pending, LOW_PTR, ROTATE) to winner index and a found flag; the FSM instantiates it once.

Verification
REQ-037 DREQ = 0001, MASK = 0, HLDA raised 2 cycles after HRQ -> HRQ 1 cycle after DREQ; DACK = 0001 and CH_ID = 0 one edge after HLDA; EOP_DONE -> all outputs 0 next edge.
REQ-038 ROTATE = 0, DREQ = 1010 -> DACK = 0010; after EOP_DONE with DREQ held, the next grant is again DACK = 0010.
REQ-039 ROTATE = 1, DREQ = 1111, four back-to-back services -> grant order ch0, ch1, ch2, ch3; LOW_PTR ends at 3.
REQ-040 DREQ = 0100 with MASK = 0100 -> HRQ stays 0; clearing MASK -> HRQ = 1 next edge.
REQ-041 In ARB_GRANT on ch2, drop HLDA -> outputs cleared next edge and LOW_PTR unchanged; also pulse RESET_N low mid-grant -> DACK = 0 immediately, LOW_PTR = 3.
REQ-042 DREQ withdrawn in ARB_REQ before HLDA rises -> HRQ drops, and a late HLDA produces no DACK.
